// File: rtl/snd_channel.sv
// snd_channel: one sound playback channel.
// Hands burst address/length to the VRAM read controller, follows burst
// progress by snooping the controller's FIFO writes, and pops one stereo
// word per sample tick to produce registered 16-bit L/R samples.
module snd_channel #(
  parameter logic [7:0]  BURST_LEN  = 8'h1F,
  parameter int unsigned SAMPLE_DIV = 2268
) (
  input  logic        ACLK,
  input  logic        ARST,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic [31:0] START_ADDR,
  input  logic [15:0] BURST_CNT,
  input  logic        LOOP,
  output logic [31:0] CH_ADDR,
  output logic [7:0]  CH_LEN,
  input  logic        FIFO_WR,
  input  logic [31:0] FIFO_DOUT,
  input  logic        FIFO_EMPTY,
  output logic        FIFO_RD,
  output logic [15:0] SAMPLE_L,
  output logic [15:0] SAMPLE_R,
  output logic        SAMPLE_VALID,
  output logic        BUSY,
  output logic        DONE,
  output logic        UNDERRUN
);

  localparam int unsigned      DIV_W       = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [31:0]      BURST_BYTES = ({24'd0, BURST_LEN} + 32'd1) << 2;
  localparam logic [23:0]      BURST_WORDS = {16'd0, BURST_LEN} + 24'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  logic             rst;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  state_e           state_q;
  logic [31:0]      base_q;
  logic [15:0]      nburst_q;
  logic             loop_q;
  logic [7:0]       beat_q;
  logic [15:0]      burst_q;
  logic [23:0]      played_q;
  logic [23:0]      clip_words;
  logic [31:0]      addr_q;
  logic [7:0]       len_q;
  logic [15:0]      sl_q;
  logic [15:0]      sr_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic             underrun_q;
  logic             fifo_rd_d;
  logic             sample_pop;

  assign rst        = ARST | RST;
  assign tick       = (div_q == DIV_LAST);
  assign clip_words = {8'd0, nburst_q} * BURST_WORDS;

  // Free-running sample-tick divider, independent of playback state.
  always_ff @(posedge ACLK) begin
    if (rst) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_W'(1);
    end
  end

  // FIFO pop: flush everything while idle, one word per tick while playing.
  always_comb begin
    fifo_rd_d  = 1'b0;
    sample_pop = 1'b0;
    case (state_q)
      S_IDLE:         fifo_rd_d = !FIFO_EMPTY;
      S_PLAY, S_DRAIN: begin
        fifo_rd_d  = tick && !FIFO_EMPTY;
        sample_pop = tick && !FIFO_EMPTY;
      end
      default:        fifo_rd_d = 1'b0;
    endcase
  end

  // Playback FSM with burst tracking, sample consumption and registered outputs.
  always_ff @(posedge ACLK) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= 32'd0;
      nburst_q   <= 16'd0;
      loop_q     <= 1'b0;
      beat_q     <= 8'd0;
      burst_q    <= 16'd0;
      played_q   <= 24'd0;
      addr_q     <= 32'd0;
      len_q      <= 8'd0;
      sl_q       <= 16'd0;
      sr_q       <= 16'd0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      if (STOP) begin
        // Abort wins over everything, including a same-cycle START.
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        len_q   <= 8'd0;
        sl_q    <= 16'd0;
        sr_q    <= 16'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            sl_q  <= 16'd0;
            sr_q  <= 16'd0;
            len_q <= 8'd0;
            if (START) begin
              underrun_q <= 1'b0;
              base_q     <= START_ADDR;
              nburst_q   <= BURST_CNT;
              loop_q     <= LOOP;
              if (BURST_CNT != 16'd0) begin
                state_q  <= S_PLAY;
                busy_q   <= 1'b1;
                len_q    <= BURST_LEN;
                addr_q   <= START_ADDR;
                beat_q   <= 8'd0;
                burst_q  <= 16'd0;
                played_q <= 24'd0;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_PLAY, S_DRAIN: begin
            if ((state_q == S_DRAIN) && (played_q == clip_words)) begin
              // Every word of the clip has been played out.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              sl_q    <= 16'd0;
              sr_q    <= 16'd0;
            end else begin
              valid_q <= tick;
              if (sample_pop) begin
                sl_q     <= FIFO_DOUT[31:16];
                sr_q     <= FIFO_DOUT[15:0];
                played_q <= played_q + 24'd1;
              end else if (tick) begin
                sl_q       <= 16'd0;
                sr_q       <= 16'd0;
                underrun_q <= 1'b1;
              end
              if ((state_q == S_PLAY) && FIFO_WR) begin
                if (beat_q == BURST_LEN) begin
                  beat_q <= 8'd0;
                  if (burst_q == (nburst_q - 16'd1)) begin
                    if (loop_q) begin
                      // Restart the clip; played count restarts with it.
                      addr_q   <= base_q;
                      burst_q  <= 16'd0;
                      played_q <= 24'd0;
                    end else begin
                      addr_q  <= addr_q + BURST_BYTES;
                      burst_q <= burst_q + 16'd1;
                      state_q <= S_DRAIN;
                      len_q   <= 8'd0;
                    end
                  end else begin
                    addr_q  <= addr_q + BURST_BYTES;
                    burst_q <= burst_q + 16'd1;
                  end
                end else begin
                  beat_q <= beat_q + 8'd1;
                end
              end
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            len_q   <= 8'd0;
          end
        endcase
      end
    end
  end

  assign CH_ADDR      = addr_q;
  assign CH_LEN       = len_q;
  assign FIFO_RD      = fifo_rd_d;
  assign SAMPLE_L     = sl_q;
  assign SAMPLE_R     = sr_q;
  assign SAMPLE_VALID = valid_q;
  assign BUSY         = busy_q;
  assign DONE         = done_q;
  assign UNDERRUN     = underrun_q;

endmodule
